// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial subtractor. Computes diff = a - b - bin (mod 2^WIDTH)
//             one bit per clock, LSB first, with one full-subtractor cell and
//             a registered borrow. Uses a start/busy/done handshake.
//  Ports    : clk   - system clock, rising edge
//             rst   - asynchronous active-high reset
//             start - request, honoured only while idle
//             a, b  - minuend / subtrahend, captured on accepted start
//             bin   - borrow-in, captured on accepted start
//             busy  - high while bits are being processed
//             done  - one-cycle completion pulse
//             diff  - registered result
//             bout  - registered borrow-out (a < b + bin, unsigned)
//             ovf   - registered two's-complement overflow
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sa_q,    sa_d;
    logic [WIDTH-1:0] sb_q,    sb_d;
    logic [WIDTH-1:0] sd_q,    sd_d;
    logic [WIDTH-1:0] diff_q,  diff_d;
    logic             br_q,    br_d;
    logic             amsb_q,  amsb_d;
    logic             bmsb_q,  bmsb_d;
    logic             bout_q,  bout_d;
    logic             ovf_q,   ovf_d;

    // Full-subtractor cell operating on the current LSBs.
    logic             dbit;
    logic             br_next;
    logic [WIDTH-1:0] sd_shift;

    always_comb begin
        dbit     = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        // Result bits enter at the MSB so that after WIDTH shifts the LSB
        // produced first has reached bit 0.
        sd_shift = {dbit, sd_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    cnt_d   = '0;
                    sd_d    = '0;
                end
            end
            S_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_shift;
                br_d  = br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_CNT) begin
                    state_d = S_DONE;
                    // Published results use the final bit computed this cycle,
                    // so they are taken from the shift input, not sd_q.
                    diff_d  = sd_shift;
                    bout_d  = br_next;
                    // Overflow only possible when operand signs differ and the
                    // result sign differs from the minuend sign.
                    ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ sd_shift[WIDTH-1]);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, multi-cycle subtractor. Computes DIFF = A - B - Bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart to the team's combinational ripple adders. It is intended for area-constrained datapaths where WIDTH-cycle latency is acceptable, and uses a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled on rising clk edge, honoured only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse, high while in DONE
diff  output  WIDTH  registered result A-B-Bin mod 2^WIDTH
bout  output  1  registered borrow-out (1 when A < B+Bin, unsigned)
ovf  output  1  registered signed overflow

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, bit counter=0, internal shift registers=0, borrow register=0. Outputs busy=0, done=0, diff=0, bout=0, ovf=0.
- Reset mid-operation: the computation is aborted immediately and all of the reset values above apply. No done pulse is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT: on a clk edge with start=1.
  - Latch a into shift register SA, b into SB, bin into the borrow register br.
  - Latch a[WIDTH-1] and b[WIDTH-1] for the overflow calculation.
  - Clear counter cnt=0 and working register SD=0.
- SHIFT, on each edge:
  - Compute d = SA[0]^SB[0]^br.
  - Compute br_next = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&br).
  - SA and SB shift right by 1.
  - SD shifts right with d inserted at the MSB.
  - cnt increments.
- SHIFT -> DONE: on the edge where cnt==WIDTH-1, i.e. after exactly WIDTH SHIFT edges.
  - On this same edge, register diff = final SD (including the last bit) and bout = final br_next.
  - ovf = (a_msb ^ b_msb) & (a_msb ^ diff[WIDTH-1]).
- DONE -> IDLE: unconditionally on the next edge.
- Output decodes: busy = (state==SHIFT); done = (state==DONE). Both are decoded from the state register only.
- Latency: start is sampled at edge E0. done is high for exactly one cycle, from edge E0+WIDTH to edge E0+WIDTH+1. The earliest next start is accepted at E0+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE: ignored. No re-latch and no queuing; in-flight operands are unaffected.
- Input stability: a, b and bin may change freely after the accepting edge.
- Result holding:
  - diff, bout and ovf hold their previous values throughout a new SHIFT phase.
  - They update only on the SHIFT->DONE edge.
  - They then hold until the next completion or reset.
- start held high continuously: one operation is accepted every WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH. bin=1 subtracts one additional unit.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> busy high 8 cycles; done pulse 8 cycles after the start edge; diff=0x1E, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0 (checks the borrow-in path).
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- During SHIFT, pulse start with a=0xFF, b=0x00 -> ignored; the first result completes unchanged; diff keeps its prior value until that done; no extra done pulse.
- Assert rst at the 4th SHIFT cycle -> busy, done, diff, bout and ovf read 0 immediately, without a clock edge. After release, a new start with a=0x03, b=0x05 -> diff=0xFE, bout=1.
- start held high for 30 cycles with a=0x09, b=0x04 -> done pulses every 10 cycles, each with diff=0x05; busy never overlaps done.
